// File: rtl/aes256_ecb_decrypt_iter_if.sv
// Handshake bundle for the iterative AES-256 ECB decryptor:
// key load, ciphertext input stream and plaintext output stream.
interface aes256_ecb_decrypt_iter_if;
    logic         key_load;
    logic [255:0] key;
    logic         key_ready;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output key_load, key, in_valid, in_data, out_ready,
        input  key_ready, in_ready, out_valid, out_data
    );

    modport slave (
        input  key_load, key, in_valid, in_data, out_ready,
        output key_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes256_ecb_decrypt_iter.sv
// Iterative AES-256 ECB decryptor: one inverse round per clock, with an on-chip
// sequential key expansion and valid/ready handshakes on input and output.
module aes256_ecb_decrypt_iter (
    input  logic                        clk,
    input  logic                        rst,
    aes256_ecb_decrypt_iter_if.slave    bus
);
    localparam int unsigned Nk       = 8;
    localparam int unsigned Nr       = 14;
    localparam int unsigned NumWords = 60;

    // Byte 0 of each ROM sits in the top bits.
    localparam logic [2047:0] Sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] InvSbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {StIdle, StKexp, StReady, StRound, StOut} fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return Sbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return InvSbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r of the column-major state is rotated right by r positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8 * i +: 8] = inv_sbox(s[8 * i +: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8 * i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [31:0]  w_q [NumWords];
    logic [31:0]  w_d [NumWords];
    logic [5:0]   cnt_q, cnt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] out_q, out_d;

    logic         key_ready, in_ready, out_valid;
    logic [31:0]  w_prev, w_old, w_new;
    logic [7:0]   rcon;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] round_core;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state logic; key_load overrides every state.
    always_comb begin
        fsm_d = fsm_q;
        if (bus.key_load) begin
            fsm_d = StKexp;
        end else begin
            case (fsm_q)
                StIdle:  fsm_d = StIdle;
                StKexp:  if (cnt_q == 6'(NumWords - 1)) fsm_d = StReady;
                StReady: if (bus.in_valid) fsm_d = StRound;
                StRound: if (rnd_q == 4'd0) fsm_d = StOut;
                StOut:   if (bus.out_ready) fsm_d = StReady;
                default: fsm_d = StIdle;
            endcase
        end
    end

    // Output decode
    always_comb begin
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm_q)
            StReady: begin
                key_ready = 1'b1;
                in_ready  = 1'b1;
            end
            StRound: key_ready = 1'b1;
            StOut: begin
                key_ready = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.key_ready = key_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_q;

    // Key schedule word n from w[n-1] and w[n-Nk].
    always_comb begin
        w_prev = w_q[cnt_q - 6'd1];
        w_old  = w_q[cnt_q - 6'(Nk)];
        rcon   = 8'h01 << (cnt_q[5:3] - 3'd1);
        if (cnt_q[2:0] == 3'd0) begin
            w_new = w_old ^ sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0};
        end else if (cnt_q[2:0] == 3'd4) begin
            w_new = w_old ^ sub_word(w_prev);
        end else begin
            w_new = w_old ^ w_prev;
        end
    end

    assign rk_idx     = (fsm_q == StReady) ? 4'(Nr) : rnd_q;
    assign rk         = {w_q[{rk_idx, 2'b00}], w_q[{rk_idx, 2'b01}],
                         w_q[{rk_idx, 2'b10}], w_q[{rk_idx, 2'b11}]};
    assign round_core = inv_sub_bytes(inv_shift_rows(blk_q)) ^ rk;

    always_comb begin
        w_d   = w_q;
        cnt_d = cnt_q;
        rnd_d = rnd_q;
        blk_d = blk_q;
        out_d = out_q;
        if (bus.key_load) begin
            for (int i = 0; i < int'(Nk); i++) begin
                w_d[i] = bus.key[255 - 32 * i -: 32];
            end
            cnt_d = 6'(Nk);
        end else begin
            case (fsm_q)
                StKexp: begin
                    w_d[cnt_q] = w_new;
                    cnt_d      = cnt_q + 6'd1;
                end
                StReady: begin
                    if (bus.in_valid) begin
                        blk_d = bus.in_data ^ rk;
                        rnd_d = 4'(Nr - 1);
                    end
                end
                StRound: begin
                    if (rnd_q != 4'd0) begin
                        blk_d = inv_mix_columns(round_core);
                        rnd_d = rnd_q - 4'd1;
                    end else begin
                        out_d = round_core;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NumWords); i++) begin
                w_q[i] <= '0;
            end
            cnt_q <= '0;
            rnd_q <= '0;
            blk_q <= '0;
            out_q <= '0;
        end else begin
            w_q   <= w_d;
            cnt_q <= cnt_d;
            rnd_q <= rnd_d;
            blk_q <= blk_d;
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_aes256_ecb_decrypt_iter.sv
// Directed bench for aes256_ecb_decrypt_iter: known-answer vectors plus
// back-to-back, backpressure, key reload, reset and early-input sequences.
module tb_aes256_ecb_decrypt_iter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    aes256_ecb_decrypt_iter_if bus ();

    aes256_ecb_decrypt_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t         vecs [3];
    logic [255:0] c3_key;
    logic [255:0] nist_key;
    logic [127:0] nist_ct [4];
    logic [127:0] nist_pt [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pulse key_load, scramble the key bus afterwards, and time key_ready.
    task automatic load_key(input logic [255:0] k, input string tag);
        int   n;
        logic saw_out;
        bus.key      = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        bus.key      = ~k;
        check({tag, " flags after load"}, 256'({bus.key_ready, bus.in_ready, bus.out_valid}), '0);
        n       = 0;
        saw_out = 1'b0;
        while (!bus.key_ready && n < 200) begin
            tick();
            n++;
            if (bus.out_valid) saw_out = 1'b1;
        end
        check({tag, " key_ready latency"}, 256'(n), 256'(52));
        check({tag, " no output during expansion"}, 256'(saw_out), '0);
    endtask

    task automatic decrypt(input logic [127:0] ct, input logic [127:0] pt, input string tag);
        int n;
        check({tag, " in_ready before accept"}, 256'(bus.in_ready), 256'(1));
        bus.in_valid  = 1'b1;
        bus.in_data   = ct;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, " out latency"}, 256'(n), 256'(14));
        check({tag, " out_data"}, 256'(bus.out_data), 256'(pt));
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   n_in;
        int   n_out;
        int   last;
        int   cyc;
        logic bad;

        errors = 0;
        checks = 0;

        c3_key     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        nist_key   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        // SP 800-38A ECB-AES256 blocks
        nist_pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        nist_ct[0] = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
        nist_pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        nist_ct[1] = 128'h591ccb10d410ed26dc5ba74a31362870;
        nist_pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        nist_ct[2] = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
        nist_pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        nist_ct[3] = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;

        vecs[0] = '{key: c3_key, ct: 128'h8ea2b7ca516745bfeafc49904b496089,
                    pt: 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{key: '0, ct: 128'hdc95c078a2408989ad48a21492842087, pt: '0};
        vecs[2] = '{key: nist_key, ct: nist_ct[0], pt: nist_pt[0]};

        bus.key_load  = 1'b0;
        bus.key       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        check("reset outputs",
              256'({bus.key_ready, bus.in_ready, bus.out_valid, bus.out_data}), '0);
        rst = 1'b0;
        tick();
        check("idle in_ready", 256'(bus.in_ready), '0);

        for (int i = 0; i < 3; i++) begin
            load_key(vecs[i].key, $sformatf("vec%0d", i));
            decrypt(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i));
        end

        // Back-to-back: in_valid held high across four blocks.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = nist_ct[0];
        n_in  = 0;
        n_out = 0;
        last  = -1;
        cyc   = 0;
        while (n_out < 4 && cyc < 300) begin
            if (bus.out_valid) begin
                check($sformatf("b2b out%0d", n_out), 256'(bus.out_data), 256'(nist_pt[n_out]));
                n_out++;
            end
            if (bus.in_ready && bus.in_valid) begin
                check($sformatf("b2b in flight at accept%0d", n_in), 256'(n_in - n_out), '0);
                if (last >= 0) begin
                    check($sformatf("b2b accept interval%0d", n_in), 256'(cyc - last), 256'(16));
                end
                last = cyc;
                n_in++;
                tick();
                cyc++;
                if (n_in < 4) bus.in_data = nist_ct[n_in];
                else bus.in_valid = 1'b0;
            end else begin
                tick();
                cyc++;
            end
        end
        check("b2b blocks delivered", 256'(n_out), 256'(4));
        tick();

        // Output backpressure for 20 clocks with the next block already offered.
        check("bp in_ready before accept", 256'(bus.in_ready), 256'(1));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = nist_ct[0];
        tick();
        bus.in_data = nist_ct[1];
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp out latency", 256'(n), 256'(14));
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.out_valid || bus.in_ready || bus.out_data !== nist_pt[0]) bad = 1'b1;
            tick();
        end
        check("bp held stable", 256'(bad), '0);
        check("bp held data", 256'(bus.out_data), 256'(nist_pt[0]));
        bus.out_ready = 1'b1;
        tick();
        check("bp release flags", 256'({bus.out_valid, bus.in_ready}), 256'(2'b01));
        tick();
        bus.in_valid = 1'b0;
        check("bp next accepted", 256'(bus.in_ready), '0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp second latency", 256'(n), 256'(14));
        check("bp second data", 256'(bus.out_data), 256'(nist_pt[1]));
        tick();

        // Key reload at round 7 aborts the block in flight.
        check("reload in_ready", 256'(bus.in_ready), 256'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = nist_ct[2];
        tick();
        bus.in_valid = 1'b0;
        repeat (6) tick();
        load_key('0, "reload");
        decrypt(128'hdc95c078a2408989ad48a21492842087, '0, "reload zero key");

        // Reset in the middle of a block.
        bus.in_valid = 1'b1;
        bus.in_data  = 128'hdc95c078a2408989ad48a21492842087;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-round reset outputs",
              256'({bus.key_ready, bus.in_ready, bus.out_valid, bus.out_data}), '0);

        // Early input: in_valid waits from reset through a full key expansion.
        bus.in_valid = 1'b1;
        bus.in_data  = vecs[0].ct;
        bad = 1'b0;
        repeat (40) begin
            tick();
            if (bus.in_ready || bus.out_valid) bad = 1'b1;
        end
        check("post-reset idle", 256'(bad), '0);
        load_key(c3_key, "early");
        decrypt(vecs[0].ct, vecs[0].pt, "early");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
